// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT butterfly sequencer: sizes, FSM encoding and bit reversal.
package ntt_pkg;

  localparam int N    = 8;
  localparam int LOGN = $clog2(N);
  localparam int DW   = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    UNLOAD = 3'd4
  } state_t;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) begin
      r[i] = v[LOGN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_bfly_addr_gen.sv
// Maps (stage, butterfly index k) to the operand addresses a, b and the twiddle index.
module ntt_bfly_addr_gen #(
  parameter int LOGN = ntt_pkg::LOGN
) (
  input  logic [LOGN-1:0] stage,
  input  logic [LOGN-2:0] k,
  output logic [LOGN-1:0] a,
  output logic [LOGN-1:0] b,
  output logic [LOGN-2:0] tw
);

  localparam logic [LOGN-1:0] ONE = LOGN'(1);
  localparam logic [LOGN-1:0] TOP = LOGN'(LOGN - 1);

  logic [LOGN-1:0] k_ext_s;
  logic [LOGN-1:0] half_s;
  logic [LOGN-1:0] low_s;

  // Low bits of k pick the position inside a group; upper bits skip over the half bit.
  always_comb begin
    k_ext_s = {1'b0, k};
    half_s  = ONE << stage;
    low_s   = k_ext_s & (half_s - ONE);
    a       = (((k_ext_s >> stage) << stage) << 1) | low_s;
    b       = a + half_s;
    tw      = low_s[LOGN-2:0] << (TOP - stage);
  end

endmodule

// File: rtl/ntt_bfly_sequencer.sv
// Forward-NTT controller: bit-reversed load, one-at-a-time DIT butterfly issue, natural-order unload.
module ntt_bfly_sequencer #(
  parameter int N    = ntt_pkg::N,
  parameter int LOGN = $clog2(N),
  parameter int DW   = ntt_pkg::DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            bf_valid,
  input  logic            bf_ready,
  output logic [DW-1:0]   bf_a,
  output logic [DW-1:0]   bf_b,
  output logic [LOGN-2:0] bf_tw_idx,
  output logic [LOGN-1:0] bf_stage,
  input  logic            res_valid,
  input  logic [DW-1:0]   res_a,
  input  logic [DW-1:0]   res_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data
);
  import ntt_pkg::*;

  localparam int KW = LOGN - 1;
  localparam logic [LOGN-1:0] ONE_A      = LOGN'(1);
  localparam logic [KW-1:0]   ONE_K      = KW'(1);
  localparam logic [LOGN-1:0] LAST_IDX   = LOGN'(N - 1);
  localparam logic [KW-1:0]   LAST_K     = KW'(N / 2 - 1);
  localparam logic [LOGN-1:0] LAST_STAGE = LOGN'(LOGN - 1);

  state_t          state_r, state_nxt_s;
  logic [DW-1:0]   mem_r     [N];
  logic [DW-1:0]   mem_nxt_s [N];
  logic [LOGN-1:0] ld_cnt_r, ld_cnt_nxt_s;
  logic [LOGN-1:0] j_r, j_nxt_s;
  logic [LOGN-1:0] stage_r, stage_nxt_s;
  logic [KW-1:0]   k_r, k_nxt_s;
  logic            done_nxt_s;
  logic [LOGN-1:0] a_s, b_s, na_s, nb_s;
  logic [KW-1:0]   tw_s, ntw_s;

  logic            busy_r, done_r, in_ready_r, bf_valid_r, out_valid_r;
  logic [DW-1:0]   bf_a_r, bf_b_r, out_data_r;
  logic [KW-1:0]   bf_tw_idx_r;
  logic [LOGN-1:0] bf_stage_r;

  // Current butterfly addresses serve write-back; next-cycle addresses feed the registered request.
  ntt_bfly_addr_gen #(.LOGN(LOGN)) u_addr_cur (
    .stage(stage_r), .k(k_r), .a(a_s), .b(b_s), .tw(tw_s)
  );
  ntt_bfly_addr_gen #(.LOGN(LOGN)) u_addr_nxt (
    .stage(stage_nxt_s), .k(k_nxt_s), .a(na_s), .b(nb_s), .tw(ntw_s)
  );

  // Next state, counters and buffer contents.
  always_comb begin
    state_nxt_s  = state_r;
    ld_cnt_nxt_s = ld_cnt_r;
    j_nxt_s      = j_r;
    stage_nxt_s  = stage_r;
    k_nxt_s      = k_r;
    done_nxt_s   = 1'b0;
    for (int i = 0; i < N; i++) begin
      mem_nxt_s[i] = mem_r[i];
    end
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s  = LOAD;
          ld_cnt_nxt_s = {LOGN{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (in_valid) begin
          mem_nxt_s[bitrev(ld_cnt_r)] = in_data;
          ld_cnt_nxt_s = ld_cnt_r + ONE_A;
          if (ld_cnt_r == LAST_IDX) begin
            state_nxt_s = ISSUE;
            stage_nxt_s = {LOGN{1'b0}};
            k_nxt_s     = {KW{1'b0}};
          end else begin
            state_nxt_s = LOAD;
          end
        end else begin
          state_nxt_s = LOAD;
        end
      end
      ISSUE: begin
        if (bf_ready) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      WAIT: begin
        if (res_valid) begin
          mem_nxt_s[a_s] = res_a;
          mem_nxt_s[b_s] = res_b;
          if (k_r == LAST_K) begin
            k_nxt_s = {KW{1'b0}};
            if (stage_r == LAST_STAGE) begin
              state_nxt_s = UNLOAD;
              j_nxt_s     = {LOGN{1'b0}};
            end else begin
              stage_nxt_s = stage_r + ONE_A;
              state_nxt_s = ISSUE;
            end
          end else begin
            k_nxt_s     = k_r + ONE_K;
            state_nxt_s = ISSUE;
          end
        end else begin
          state_nxt_s = WAIT;
        end
      end
      UNLOAD: begin
        if (out_ready) begin
          j_nxt_s = j_r + ONE_A;
          if (j_r == LAST_IDX) begin
            state_nxt_s = IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = UNLOAD;
          end
        end else begin
          state_nxt_s = UNLOAD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, buffer and output registers; outputs are loaded from next-cycle values so they line up with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ld_cnt_r    <= {LOGN{1'b0}};
      j_r         <= {LOGN{1'b0}};
      stage_r     <= {LOGN{1'b0}};
      k_r         <= {KW{1'b0}};
      for (int i = 0; i < N; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      bf_valid_r  <= 1'b0;
      out_valid_r <= 1'b0;
      bf_a_r      <= {DW{1'b0}};
      bf_b_r      <= {DW{1'b0}};
      bf_tw_idx_r <= {KW{1'b0}};
      bf_stage_r  <= {LOGN{1'b0}};
      out_data_r  <= {DW{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      ld_cnt_r    <= ld_cnt_nxt_s;
      j_r         <= j_nxt_s;
      stage_r     <= stage_nxt_s;
      k_r         <= k_nxt_s;
      for (int i = 0; i < N; i++) begin
        mem_r[i] <= mem_nxt_s[i];
      end
      busy_r      <= (state_nxt_s != IDLE);
      done_r      <= done_nxt_s;
      in_ready_r  <= (state_nxt_s == LOAD);
      bf_valid_r  <= (state_nxt_s == ISSUE);
      out_valid_r <= (state_nxt_s == UNLOAD);
      if (state_nxt_s == ISSUE) begin
        bf_a_r      <= mem_nxt_s[na_s];
        bf_b_r      <= mem_nxt_s[nb_s];
        bf_tw_idx_r <= ntw_s;
        bf_stage_r  <= stage_nxt_s;
      end else begin
        bf_a_r      <= {DW{1'b0}};
        bf_b_r      <= {DW{1'b0}};
        bf_tw_idx_r <= {KW{1'b0}};
        bf_stage_r  <= {LOGN{1'b0}};
      end
      if (state_nxt_s == UNLOAD) begin
        out_data_r <= mem_nxt_s[j_nxt_s];
      end else begin
        out_data_r <= {DW{1'b0}};
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign in_ready  = in_ready_r;
  assign bf_valid  = bf_valid_r;
  assign bf_a      = bf_a_r;
  assign bf_b      = bf_b_r;
  assign bf_tw_idx = bf_tw_idx_r;
  assign bf_stage  = bf_stage_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // Current-butterfly twiddle is only needed for the next request.
  logic unused_s;
  assign unused_s = ^tw_s;

endmodule

// File: tb/tb_ntt_bfly_sequencer.sv
// Randomized bench for ntt_bfly_sequencer against a loop-based NTT-order reference model.
module tb_ntt_bfly_sequencer;

  logic       clk, rst_n, start, busy, done;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       bf_valid, bf_ready;
  logic [7:0] bf_a, bf_b;
  logic [1:0] bf_tw_idx;
  logic [2:0] bf_stage;
  logic       res_valid;
  logic [7:0] res_a, res_b;
  logic       out_valid, out_ready;
  logic [7:0] out_data;

  int total, bad;
  int exp_a [12];
  int exp_b [12];
  int exp_tw [12];
  int exp_st [12];
  int exp_out [8];

  ntt_bfly_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bf_valid(bf_valid), .bf_ready(bf_ready), .bf_a(bf_a), .bf_b(bf_b),
    .bf_tw_idx(bf_tw_idx), .bf_stage(bf_stage),
    .res_valid(res_valid), .res_a(res_a), .res_b(res_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_busy"},      32'(busy),      32'd0);
    check_val({tag, "_done"},      32'(done),      32'd0);
    check_val({tag, "_in_ready"},  32'(in_ready),  32'd0);
    check_val({tag, "_bf_valid"},  32'(bf_valid),  32'd0);
    check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, "_bf_a"},      32'(bf_a),      32'd0);
    check_val({tag, "_bf_b"},      32'(bf_b),      32'd0);
    check_val({tag, "_bf_tw"},     32'(bf_tw_idx), 32'd0);
    check_val({tag, "_bf_stage"},  32'(bf_stage),  32'd0);
    check_val({tag, "_out_data"},  32'(out_data),  32'd0);
  endtask

  // Reference: bit-reverse placement, then classic group/offset DIT loops with a+b / a-b butterflies.
  task automatic build_model(input logic [7:0] x [8]);
    logic [7:0] m [8];
    logic [7:0] ta, tb;
    int n, half, a, b, r;
    for (int i = 0; i < 8; i++) begin
      r = 0;
      for (int bi = 0; bi < 3; bi++) begin
        if (((i >> bi) & 1) == 1) r = r | (1 << (2 - bi));
      end
      m[r] = x[i];
    end
    n = 0;
    for (int s = 0; s < 3; s++) begin
      half = 1 << s;
      for (int g = 0; g < 8; g += 2 * half) begin
        for (int j = 0; j < half; j++) begin
          a = g + j;
          b = a + half;
          exp_a[n]  = int'(m[a]);
          exp_b[n]  = int'(m[b]);
          exp_tw[n] = j * (4 / half);
          exp_st[n] = s;
          n++;
          ta = m[a];
          tb = m[b];
          m[a] = ta + tb;
          m[b] = ta - tb;
        end
      end
    end
    for (int i = 0; i < 8; i++) exp_out[i] = int'(m[i]);
  endtask

  task automatic run_xform(input logic [7:0] x [8], input bit stall, input int abort_stage,
                           output logic [7:0] got [8], output int ncyc);
    int iidx, ridx, oidx, lat;
    bit req_hold, out_hold, res_pend, exp_done, fin;
    logic [7:0] h_a, h_b, h_out, p_a, p_b;
    logic [1:0] h_tw;
    logic [2:0] h_st;
    iidx = 0; ridx = 0; oidx = 0; lat = 0; ncyc = 0;
    req_hold = 1'b0; out_hold = 1'b0; res_pend = 1'b0; exp_done = 1'b0; fin = 1'b0;
    h_a = 8'd0; h_b = 8'd0; h_out = 8'd0; p_a = 8'd0; p_b = 8'd0; h_tw = 2'd0; h_st = 3'd0;
    for (int i = 0; i < 8; i++) got[i] = 8'd0;
    build_model(x);
    @(negedge clk);
    start = 1'b1;
    while (!fin && ncyc < 3000) begin
      @(negedge clk);
      ncyc++;
      start = 1'b0; in_valid = 1'b0; in_data = 8'($urandom); bf_ready = 1'b0;
      res_valid = 1'b0; res_a = 8'($urandom); res_b = 8'($urandom); out_ready = 1'b0;
      if (ncyc == 1) check_val("in_ready_after_start", 32'(in_ready), 32'd1);
      if (exp_done) begin
        check_val("done_pulse", 32'(done), 32'd1);
        check_val("busy_at_done", 32'(busy), 32'd0);
        check_val("request_count", 32'(ridx), 32'd12);
        fin = 1'b1;
      end else begin
        if (done) check_val("done_early", 32'(done), 32'd0);
        if (abort_stage >= 0 && bf_valid && int'(bf_stage) == abort_stage) begin
          rst_n = 1'b0;
          @(negedge clk);
          check_zero("abort");
          rst_n = 1'b1;
          return;
        end
        // butterfly request side
        if (req_hold) begin
          check_val("bf_hold_valid", 32'(bf_valid), 32'd1);
          check_val("bf_hold_a", 32'(bf_a), 32'(h_a));
          check_val("bf_hold_b", 32'(bf_b), 32'(h_b));
          check_val("bf_hold_tw", 32'(bf_tw_idx), 32'(h_tw));
          check_val("bf_hold_stage", 32'(bf_stage), 32'(h_st));
        end else if (bf_valid) begin
          if (ridx < 12) begin
            check_val("bf_a", 32'(bf_a), exp_a[ridx]);
            check_val("bf_b", 32'(bf_b), exp_b[ridx]);
            check_val("bf_tw", 32'(bf_tw_idx), exp_tw[ridx]);
            check_val("bf_stage", 32'(bf_stage), exp_st[ridx]);
          end else begin
            check_val("extra_request", 32'(ridx), 32'd11);
          end
          ridx++;
        end
        if (bf_valid) begin
          bf_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
          if (stall && $urandom_range(0, 2) == 0) res_valid = 1'b1;
          h_a = bf_a; h_b = bf_b; h_tw = bf_tw_idx; h_st = bf_stage;
          req_hold = !bf_ready;
          if (bf_ready) begin
            res_pend = 1'b1;
            lat = stall ? int'($urandom_range(0, 5)) : 0;
            p_a = bf_a + bf_b;
            p_b = bf_a - bf_b;
          end
        end else begin
          req_hold = 1'b0;
          if (res_pend) begin
            if (lat == 0) begin
              res_valid = 1'b1; res_a = p_a; res_b = p_b; res_pend = 1'b0;
            end else begin
              lat--;
            end
          end
        end
        // load side
        if (in_ready) begin
          if (iidx >= 8) begin
            check_val("load_overrun", 32'(iidx), 32'd7);
          end else if (!stall || $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1; in_data = x[iidx]; iidx++;
          end
        end else if (stall && $urandom_range(0, 3) == 0) begin
          in_valid = 1'b1;
        end
        // unload side
        if (out_hold) begin
          check_val("out_hold_valid", 32'(out_valid), 32'd1);
          check_val("out_hold_data", 32'(out_data), 32'(h_out));
        end
        if (out_valid) begin
          out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
          h_out = out_data;
          out_hold = !out_ready;
          if (out_ready) begin
            if (oidx < 8) begin
              check_val("out_data", 32'(out_data), exp_out[oidx]);
              got[oidx] = out_data;
            end else begin
              check_val("extra_output", 32'(oidx), 32'd7);
            end
            if (oidx == 7) exp_done = 1'b1;
            oidx++;
          end
        end else begin
          out_hold = 1'b0;
        end
        if (stall && busy && $urandom_range(0, 7) == 0) start = 1'b1;
      end
    end
    if (!fin) check_val("timeout", 32'(ncyc), 32'd0);
  endtask

  initial begin
    logic [7:0] x [8];
    logic [7:0] got [8];
    logic [7:0] ref_got [8];
    int ncyc;
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0; bf_ready = 1'b0;
    res_valid = 1'b0; res_a = 8'd0; res_b = 8'd0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) x[i] = 8'(i);
    run_xform(x, 1'b0, -1, got, ncyc);
    check_val("cycles_to_done", 32'(ncyc), 32'd41);

    for (int i = 0; i < 8; i++) x[i] = 8'd1;
    run_xform(x, 1'b0, -1, got, ncyc);
    for (int i = 0; i < 8; i++) check_val("all_ones_out", 32'(got[i]), (i == 0) ? 32'd8 : 32'd0);

    for (int i = 0; i < 8; i++) x[i] = (i == 0) ? 8'd1 : 8'd0;
    run_xform(x, 1'b0, -1, got, ncyc);
    for (int i = 0; i < 8; i++) check_val("impulse_out", 32'(got[i]), 32'd1);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 8; i++) x[i] = 8'($urandom);
      run_xform(x, 1'b0, -1, ref_got, ncyc);
      run_xform(x, 1'b1, -1, got, ncyc);
      for (int i = 0; i < 8; i++) check_val("stall_vs_nostall", 32'(got[i]), 32'(ref_got[i]));
    end

    for (int i = 0; i < 8; i++) x[i] = 8'($urandom);
    run_xform(x, 1'b1, 1, got, ncyc);
    for (int i = 0; i < 8; i++) x[i] = 8'($urandom);
    run_xform(x, 1'b1, -1, got, ncyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
